maxpool_sched: RTL and testbench
================================

Name: maxpool_sched

Overview:
Round-robin scheduler that shares one maxpool unit among NUM_CH feature-map producers (conv output channels).
- Accepts a 6x6 8-bit map (288 bits) from the winning requester and launches the pool unit with a 1-cycle valid pulse.
- Holds the input stable while the pool unit runs, then returns the 3x3 result (72 bits) to that requester.
- Enforces the pool unit's post-completion gap and a watchdog timeout.
- Sits between the conv channel buffers and the single maxpool instance.

Parameters:
NUM_CH, 4, number of requesters (2..8)
IN_W, 288, input map width (36 x 8 bit)
OUT_W, 72, pooled result width (9 x 8 bit)
GAP_CYC, 2, idle cycles forced after each result before the next launch (pool unit counter wrap)
TIMEOUT_CYC, 31, max cycles in WAIT before abort

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_i  in  NUM_CH  level request per channel; held until gnt_o seen, dropped the cycle after
req_data_i  in  NUM_CH*IN_W  map per channel; slice k = [(k+1)*IN_W-1 -: IN_W]
gnt_o  out  NUM_CH  one-hot 1-cycle pulse: request accepted, data captured
resp_valid_o  out  NUM_CH  one-hot 1-cycle pulse: resp_data_o valid for that channel
resp_data_o  out  OUT_W  pooled result, held until next response
pool_valid_o  out  1  launch pulse to maxpool unit
pool_data_o  out  IN_W  map to maxpool unit, stable from launch until return to IDLE
pool_valid_i  in  1  completion pulse from maxpool unit
pool_data_i  in  OUT_W  result from maxpool unit
busy_o  out  1  high in every state except IDLE
err_o  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset: all outputs 0; state IDLE; RR pointer = NUM_CH-1, so ch0 has first priority; hold and result registers 0; timers 0.
- FSM states: IDLE, LAUNCH, WAIT, RESP, GAP.
- IDLE: if any req_i bit is set, the arbiter picks a winner k, searching from pointer+1 upward with wrap.
  - At that edge: capture req_data_i slice k into the hold register, record k, set pointer = k, go to LAUNCH.
  - If no request, stay in IDLE.
- LAUNCH (exactly 1 cycle): gnt_o[k]=1, pool_valid_o=1, pool_data_o = hold register; go to WAIT.
- WAIT: pool_data_o stays held. The timer increments each cycle.
  - pool_valid_i=1: capture pool_data_i into resp_data_o, go to RESP.
  - Timer reaches TIMEOUT_CYC: set resp_data_o=0, set err_o=1, go to RESP.
  - If pool_valid_i arrives in the same cycle the timer expires, pool_valid_i wins and err_o is not set.
- RESP (1 cycle): resp_valid_o[k]=1; go to GAP and clear the timer.
- GAP: GAP_CYC cycles with all pulses low, then IDLE. Requests arriving during busy states wait; they are never lost and are not granted early.
- Latency:
  - Request seen in IDLE at cycle T -> gnt_o and pool_valid_o at T+1.
  - pool_valid_i at cycle P -> resp_valid_o at P+1.
  - Earliest next grant is P+2+GAP_CYC.
- pool_valid_i outside WAIT is ignored.
- A requester deasserting req_i before grant is simply not selected; no error.
- One-hot guarantee: at most one bit of gnt_o and of resp_valid_o is set in any cycle.
- Simultaneous requests: strict round-robin.
  - All 4 requesting continuously gives grant order 0,1,2,3,0,…
  - After ch2 wins, the next search starts at ch3.
- Reset mid-operation (any state): immediate return to reset values. The maxpool unit shares rst_n, so no drain is needed.

Decomposition:
- Package maxpool_pkg holds:
  - the state encoding (5 states, 3 bits);
  - constants PIX_W=8, MAP_PIX=36, POOL_PIX=9, IN_W/OUT_W derived from them.
- Sub-module rr_arbiter (NUM_CH param) contains:
  - inputs req and pointer;
  - outputs one-hot grant and winner index;
  - combinational priority rotate only.
- FSM, hold register, timers and response mux stay in maxpool_sched.

Test Plan:
1. Single request, fixed-latency stub: req_i=4'b0001, map bytes 0..35 = 0x00..0x23; stub returns 72'h0102…09 18 cycles after launch.
   -> gnt_o=0001 at T+1; pool_data_o stable through WAIT; resp_valid_o=0001 with resp_data_o=72'h0102…09 one cycle after stub valid.
2. All four request together, each with a distinct map; stub echoes the channel id in byte 0.
   -> grants in order 0,1,2,3; consecutive launches separated by at least GAP_CYC idle cycles after each RESP; each response goes to the correct channel.
3. RR fairness: ch1 and ch3 request continuously for 6 transactions.
   -> grant order 1,3,1,3,1,3; ch1 is never granted twice in a row.
4. Timeout: stub never answers.
   -> resp_valid_o pulses with resp_data_o=0 exactly TIMEOUT_CYC+1 cycles after LAUNCH; err_o=1 and stays 1; the next request is still serviced normally.
5. Race and spurious valid:
   - pool_valid_i coincides with timer expiry -> normal response, err_o stays 0.
   - Spurious pool_valid_i while IDLE -> no resp_valid_o.
6. Reset mid-operation: assert rst_n=0 during WAIT.
   -> all outputs 0 asynchronously; after release, ch0 is granted first when all channels request.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared definitions for the maxpool scheduler slice.
// Holds the scheduler state encoding and the map/result geometry
// (6x6 input map of 8-bit pixels, 3x3 pooled result).
package maxpool_pkg;

  localparam int PIX_W    = 8;
  localparam int MAP_PIX  = 36;
  localparam int POOL_PIX = 9;
  localparam int IN_W     = PIX_W * MAP_PIX;
  localparam int OUT_W    = PIX_W * POOL_PIX;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESP   = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority rotate.
// The search starts one position above ptr and wraps, so the channel
// that won last time has the lowest priority.
// Ports:
//   req   - request vector, one bit per channel
//   ptr   - index of the most recent winner
//   grant - one-hot winner (all zero when no request)
//   idx   - binary index of the winner (0 when no request)
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  output logic [NUM_CH-1:0]         grant,
  output logic [$clog2(NUM_CH)-1:0] idx
);

  localparam int CH_W = $clog2(NUM_CH);

  always_comb begin : arb
    int  j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      j = (int'(ptr) + i) % NUM_CH;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = CH_W'(j);
      end
    end
  end

endmodule

// File: rtl/maxpool_sched.sv
// Round-robin scheduler sharing one maxpool unit among NUM_CH producers.
// Captures the winning map, launches the pool unit, holds the map while it
// runs, returns the result (or zero on watchdog timeout) to the winner and
// enforces a quiet gap before the next launch.
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   req_i, req_data_i    - per-channel level request and 6x6 map
//   gnt_o                - one-hot accept pulse
//   resp_valid_o         - one-hot result pulse; resp_data_o holds result
//   pool_valid_o/data_o  - launch pulse and held map to the pool unit
//   pool_valid_i/data_i  - completion pulse and result from the pool unit
//   busy_o               - scheduler not idle
//   err_o                - sticky watchdog timeout flag
//
// state  | meaning
// IDLE   | arbitrate; capture winner's map on the edge
// LAUNCH | one cycle: grant + pool launch pulse
// WAIT   | pool unit running; watchdog counting
// RESP   | one cycle: result pulse to the owning channel
// GAP    | quiet cycles before arbitration resumes
module maxpool_sched #(
  parameter int NUM_CH      = 4,
  parameter int IN_W        = maxpool_pkg::IN_W,
  parameter int OUT_W       = maxpool_pkg::OUT_W,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 31
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH*IN_W-1:0]   req_data_i,
  output logic [NUM_CH-1:0]        gnt_o,
  output logic [NUM_CH-1:0]        resp_valid_o,
  output logic [OUT_W-1:0]         resp_data_o,
  output logic                     pool_valid_o,
  output logic [IN_W-1:0]          pool_data_o,
  input  logic                     pool_valid_i,
  input  logic [OUT_W-1:0]         pool_data_i,
  output logic                     busy_o,
  output logic                     err_o
);

  import maxpool_pkg::*;

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + GAP_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_TO_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  // The IDLE arbitration cycle is itself quiet, so GAP only needs to cover
  // GAP_CYC-1 cycles to leave GAP_CYC quiet cycles between RESP and LAUNCH.
  localparam logic [TMR_W-1:0] TMR_GAP_LAST = TMR_W'((GAP_CYC > 1) ? GAP_CYC - 2 : 0);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ptr_q, cur_ch_q, win_idx;
  logic [NUM_CH-1:0] win_gnt;
  logic [IN_W-1:0]   hold_q;
  logic [OUT_W-1:0]  resp_q;
  logic [TMR_W-1:0]  tmr_q;
  logic              err_q;
  logic              timed_out;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req   (req_i),
    .ptr   (ptr_q),
    .grant (win_gnt),
    .idx   (win_idx)
  );

  always_comb begin
    state_d      = state_q;
    timed_out    = 1'b0;
    gnt_o        = '0;
    resp_valid_o = '0;
    pool_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|win_gnt) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        gnt_o        = NUM_CH'(1) << cur_ch_q;
        pool_valid_o = 1'b1;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion in the expiry cycle takes priority over the timeout.
        if (pool_valid_i) begin
          state_d = ST_RESP;
        end else if (tmr_q == TMR_TO_LAST) begin
          state_d   = ST_RESP;
          timed_out = 1'b1;
        end
      end
      ST_RESP: begin
        resp_valid_o = NUM_CH'(1) << cur_ch_q;
        state_d      = (GAP_CYC > 1) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (tmr_q == TMR_GAP_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= CH_W'(NUM_CH - 1);
      cur_ch_q <= '0;
      hold_q   <= '0;
      resp_q   <= '0;
      tmr_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (|win_gnt) begin
            hold_q   <= req_data_i[win_idx*IN_W +: IN_W];
            cur_ch_q <= win_idx;
            ptr_q    <= win_idx;
          end
        end
        ST_WAIT: begin
          tmr_q <= tmr_q + TMR_W'(1);
          if (pool_valid_i) begin
            resp_q <= pool_data_i;
          end else if (timed_out) begin
            resp_q <= '0;
            err_q  <= 1'b1;
          end
        end
        ST_RESP: tmr_q <= '0;
        ST_GAP:  tmr_q <= (state_d == ST_IDLE) ? '0 : tmr_q + TMR_W'(1);
        default: ;
      endcase
    end
  end

  assign pool_data_o = hold_q;
  assign resp_data_o = resp_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_maxpool_sched.sv
module tb_maxpool_sched;

  localparam int NUM_CH      = 4;
  localparam int IN_W        = 288;
  localparam int OUT_W       = 72;
  localparam int GAP_CYC     = 2;
  localparam int TIMEOUT_CYC = 31;
  localparam logic [63:0] ECHO_UP = 64'hC0FFEE0012345678;

  logic                   clk;
  logic                   rst_n;
  logic [NUM_CH-1:0]      req_i;
  logic [NUM_CH*IN_W-1:0] req_data_i;
  logic [NUM_CH-1:0]      gnt_o;
  logic [NUM_CH-1:0]      resp_valid_o;
  logic [OUT_W-1:0]       resp_data_o;
  logic                   pool_valid_o;
  logic [IN_W-1:0]        pool_data_o;
  logic                   pool_valid_i;
  logic [OUT_W-1:0]       pool_data_i;
  logic                   busy_o;
  logic                   err_o;

  maxpool_sched #(
    .NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W),
    .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_data_i(req_data_i),
    .gnt_o(gnt_o), .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
    .pool_valid_o(pool_valid_o), .pool_data_o(pool_data_o),
    .pool_valid_i(pool_valid_i), .pool_data_i(pool_data_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int last_resp = 0;

  // timing: 0 none, 1 grant one cycle after request from idle, 2 back-to-back gap
  typedef struct {
    logic [NUM_CH-1:0] set_req;
    int                ch;
    int                delay;   // -1: pool unit never answers
    bit                echo;
    logic [OUT_W-1:0]  data;
    bit                drop;
    bit                exp_err;
    int                timing;
  } vec_t;

  typedef struct {
    int               ch;
    logic [OUT_W-1:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [NUM_CH-1:0] oh(input int c);
    oh = '0;
    oh[c] = 1'b1;
  endfunction

  function automatic logic [IN_W-1:0] mk_map(input int k);
    mk_map = '0;
    for (int i = 0; i < 36; i++)
      mk_map[i*8 +: 8] = (i == 0) ? 8'(k) : 8'(k * 64 + i);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},   gnt_o,        '0);
    check({tag, "_resp_v"}, resp_valid_o, '0);
    check({tag, "_resp_d"}, resp_data_o,  '0);
    check({tag, "_pool_v"}, pool_valid_o, '0);
    check({tag, "_pool_d"}, pool_data_o,  '0);
    check({tag, "_busy"},  busy_o,       '0);
    check({tag, "_err"},   err_o,        '0);
  endtask

  task automatic run_vec(input vec_t v);
    int waited, launch, n;
    logic [IN_W-1:0]  map;
    logic [OUT_W-1:0] expd;
    bit stable;
    exp_t e;
    if (v.timing == 1) repeat (GAP_CYC + 2) @(negedge clk);
    req_i  = req_i | v.set_req;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (gnt_o == '0 && waited < 200);
    if (gnt_o == '0) begin
      total++;
      bad++;
      $display("FAIL grant_wait: got no grant want ch%0d", v.ch);
      return;
    end
    launch = cyc;
    map    = mk_map(v.ch);
    if (v.timing == 1) check("grant_latency", waited, 1);
    if (v.timing == 2) check("launch_gap", launch - last_resp, GAP_CYC + 1);
    check("gnt", gnt_o, oh(v.ch));
    check("pool_valid", pool_valid_o, 1'b1);
    check("pool_data", pool_data_o, map);
    expd = v.echo ? {ECHO_UP, 8'(v.ch)} : ((v.delay < 0) ? '0 : v.data);
    e.ch = v.ch;
    e.data = expd;
    sb.push_back(e);
    if (v.drop) req_i[v.ch] = 1'b0;

    n = (v.delay < 0) ? TIMEOUT_CYC : v.delay;
    stable = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pool_data_o !== map || resp_valid_o != '0 || gnt_o != '0 || pool_valid_o) stable = 1'b0;
    end
    check("hold_stable", stable, 1'b1);
    if (v.delay >= 0) begin
      pool_valid_i = 1'b1;
      pool_data_i  = v.echo ? {ECHO_UP, pool_data_o[7:0]} : v.data;
    end
    @(negedge clk);
    pool_valid_i = 1'b0;
    pool_data_i  = '0;
    e = sb.pop_front();
    check("resp_valid", resp_valid_o, oh(e.ch));
    check("resp_data", resp_data_o, e.data);
    check("err", err_o, v.exp_err);
    last_resp = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int waited;
    rst_n        = 1'b0;
    req_i        = '0;
    pool_valid_i = 1'b0;
    pool_data_i  = '0;
    for (int k = 0; k < NUM_CH; k++) req_data_i[k*IN_W +: IN_W] = mk_map(k);

    //         set_req  ch dly echo data                    drop err timing
    vecs.push_back('{4'b1111, 0, 5, 1'b1, 72'h0, 1'b1, 1'b0, 1});
    vecs.push_back('{4'b0000, 1, 7, 1'b1, 72'h0, 1'b1, 1'b0, 2});
    vecs.push_back('{4'b0000, 2, 3, 1'b1, 72'h0, 1'b1, 1'b0, 2});
    vecs.push_back('{4'b0000, 3, 9, 1'b1, 72'h0, 1'b1, 1'b0, 2});
    vecs.push_back('{4'b0001, 0, 18, 1'b0, 72'h010203040506070809, 1'b1, 1'b0, 1});
    vecs.push_back('{4'b1010, 1, 4, 1'b1, 72'h0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'b0000, 3, 4, 1'b1, 72'h0, 1'b0, 1'b0, 2});
    vecs.push_back('{4'b0000, 1, 6, 1'b1, 72'h0, 1'b0, 1'b0, 2});
    vecs.push_back('{4'b0000, 3, 2, 1'b1, 72'h0, 1'b0, 1'b0, 2});
    vecs.push_back('{4'b0000, 1, 5, 1'b1, 72'h0, 1'b1, 1'b0, 2});
    vecs.push_back('{4'b0000, 3, 1, 1'b1, 72'h0, 1'b1, 1'b0, 2});
    vecs.push_back('{4'b1000, 3, TIMEOUT_CYC, 1'b0, 72'hDEADBEEF0011223344, 1'b1, 1'b0, 1});
    vecs.push_back('{4'b0100, 2, -1, 1'b0, 72'h0, 1'b1, 1'b1, 1});
    vecs.push_back('{4'b0010, 1, 8, 1'b0, 72'h555555555555555555, 1'b1, 1'b1, 1});

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // completion pulse while idle must not produce a response
    repeat (3) @(negedge clk);
    pool_valid_i = 1'b1;
    pool_data_i  = 72'hFFFFFFFFFFFFFFFFFF;
    @(negedge clk);
    pool_valid_i = 1'b0;
    pool_data_i  = '0;
    check("spurious_resp_v", resp_valid_o, '0);
    check("spurious_busy", busy_o, 1'b0);
    @(negedge clk);
    check("spurious_resp_v2", resp_valid_o, '0);
    check("spurious_resp_d", resp_data_o, 72'hDEADBEEF0011223344);

    for (int i = 12; i < vecs.size(); i++) run_vec(vecs[i]);

    // reset in the middle of WAIT
    repeat (GAP_CYC + 2) @(negedge clk);
    req_i  = 4'b0100;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (gnt_o == '0 && waited < 200);
    check("mid_gnt", gnt_o, 4'b0100);
    req_i = '0;
    repeat (3) @(negedge clk);
    check("mid_busy", busy_o, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    req_i = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_gnt", gnt_o, 4'b0001);
    check("post_rst_pool_d", pool_data_o, mk_map(0));
    req_i = '0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
